// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter with open-drain pull-low enables.
// Optional PS2clk glitch filter: define PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2clk,
  input  logic       key_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // state     | meaning
  // IDLE      | lines released, ready for a byte
  // INHIBIT   | PS2clk held low to request-to-send
  // SEND      | start bit driven, shifting data/parity/stop on device fe
  // ACK       | waiting for device ACK on 11th fe
  // WAIT_IDLE | waiting for both lines high before reporting done
  typedef enum logic [2:0] {
    IDLE, INHIBIT, SEND, ACK, WAIT_IDLE
  } state_t;

  localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          clk_oe_d, data_oe_d, done_d, err_d;

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_sync, dat_sync, clk_line, clk_prev_q, fe, tmo;

  // Sync flops reset high so an idle bus never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2clk};
      dat_sync_q <= {dat_sync_q[0], key_data};
    end
  end

  assign clk_sync = clk_sync_q[1];
  assign dat_sync = dat_sync_q[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       clk_filt_q;
  logic [2:0] filt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= 3'd0;
    end else if (clk_sync != clk_filt_q) begin
      if (filt_cnt_q == 3'd7) begin
        clk_filt_q <= clk_sync;
        filt_cnt_q <= 3'd0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 3'd1;
      end
    end else begin
      filt_cnt_q <= 3'd0;
    end
  end

  assign clk_line = clk_filt_q;
`else
  assign clk_line = clk_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) clk_prev_q <= 1'b1;
    else     clk_prev_q <= clk_line;
  end

  assign fe  = clk_prev_q & ~clk_line;
  assign tmo = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_d     = par_q;
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (tx_valid) begin
          data_d    = tx_data;
          par_d     = ~^tx_data;
          timer_d   = TW'(INHIBIT_CYCLES - 1);
          bit_cnt_d = 4'd0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (tmo) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          timer_d   = TW'(TIMEOUT_CYCLES - 1);
          bit_cnt_d = 4'd0;
          state_d   = SEND;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      SEND: begin
        if (fe) begin
          timer_d = TW'(TIMEOUT_CYCLES - 1);
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~data_q[bit_cnt_q[2:0]];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~par_q;
            bit_cnt_d = 4'd9;
          end else begin
            data_oe_d = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ACK;
          end
        end else if (tmo) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          bit_cnt_d = 4'd0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      ACK: begin
        if (fe) begin
          if (!dat_sync) begin
            timer_d = TW'(TIMEOUT_CYCLES - 1);
            state_d = WAIT_IDLE;
          end else begin
            timer_d = '0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          timer_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (fe) begin
          timer_d = TW'(TIMEOUT_CYCLES - 1);
        end else if (tmo) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        timer_d   = '0;
        bit_cnt_d = 4'd0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= 4'd0;
      data_q      <= 8'd0;
      par_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_q       <= par_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_done     <= done_d;
      tx_err      <= err_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Glitch-injection case is built only with PS2_TX_GLITCH_FILTER_EN.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       PS2clk, key_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_pull, dev_data_pull;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  assign PS2clk   = ~(ps2_clk_oe | dev_clk_pull);
  assign key_data = ~(ps2_data_oe | dev_data_pull);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .PS2clk(PS2clk), .key_data(key_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request a byte and check the inhibit window and start bit.
  task automatic start_tx(input logic [7:0] d);
    int cnt;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("ready_drop", 32'(tx_ready), 32'd0);
    cnt = 0;
    while (ps2_clk_oe && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("inhibit_len", 32'(cnt), 32'(INH));
    chk("start_bit_oe", 32'(ps2_data_oe), 32'd1);
  endtask

  task automatic dev_xfer(input bit ack, input int rst_at, input bit poke, input bit glitch,
                          output logic [10:0] frame);
    frame = '0;
    repeat (20) @(negedge clk);
    frame[0] = key_data;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_pull = 1'b1;
      if (i == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        dev_clk_pull = 1'b0;
        return;
      end
      if (poke && i == 5) begin
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_ready", 32'(tx_ready), 32'd0);
        chk("busy_busy", 32'(tx_busy), 32'd1);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (17) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_clk_pull = 1'b0;
      frame[i] = key_data;
      if (glitch) begin
        repeat (5) @(negedge clk);
        dev_clk_pull = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_pull = 1'b0;
        repeat (12) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
    if (ack) dev_data_pull = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_pull = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_pull = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_pull = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic send_ok(input string tag, input logic [7:0] d, input logic [10:0] exp_frame,
                         input bit poke, input bit glitch);
    int d0, e0;
    logic [10:0] fr;
    start_tx(d);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_xfer(1'b1, 0, poke, glitch, fr);
    wait_result(d0, e0);
    chk({tag, "_frame"}, 32'(fr), 32'(exp_frame));
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
    chk({tag, "_idle"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d0, e0, n;
    logic [10:0] fr;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk_pull = 1'b0;
    dev_data_pull = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ready0", 32'(tx_ready), 32'd1);
    chk("rst_busy0", 32'(tx_busy), 32'd0);
    chk("rst_clkoe0", 32'(ps2_clk_oe), 32'd0);
    chk("rst_dataoe0", 32'(ps2_data_oe), 32'd0);
    chk("rst_done0", 32'(tx_done), 32'd0);
    chk("rst_err0", 32'(tx_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED: six ones -> parity 1; frame = stop,par,data,start
    send_ok("ed", 8'hED, 11'b1_1_11101101_0, 1'b0, 1'b0);

    // 0xF4 (parity 0) with an ignored request mid-transfer, then 0x00 (parity 1)
    send_ok("f4", 8'hF4, 11'b1_0_11110100_0, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    chk("no_queue_clk", 32'(ps2_clk_oe), 32'd0);
    chk("no_queue_ready", 32'(tx_ready), 32'd1);
    send_ok("zero", 8'h00, 11'b1_1_00000000_0, 1'b0, 1'b0);

    // Device never clocks: err exactly TMO cycles after clock release
    e0 = err_cnt;
    d0 = done_cnt;
    start_tx(8'h5A);
    n = 0;
    while (!tx_err && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'(TMO));
    chk("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("tmo_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    chk("tmo_err_width", 32'(tx_err), 32'd0);
    chk("tmo_ready", 32'(tx_ready), 32'd1);
    chk("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
    chk("tmo_done_cnt", 32'(done_cnt - d0), 32'd0);

    // No ACK from device
    start_tx(8'hED);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_xfer(1'b0, 0, 1'b0, 1'b0, fr);
    wait_result(d0, e0);
    chk("nack_err", 32'(err_cnt - e0), 32'd1);
    chk("nack_done", 32'(done_cnt - d0), 32'd0);
    chk("nack_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("nack_ready", 32'(tx_ready), 32'd1);

    // Reset on the 5th device clock, then a clean 0x55 (four ones -> parity 1)
    start_tx(8'hED);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_xfer(1'b1, 5, 1'b0, 1'b0, fr);
    repeat (30) @(negedge clk);
    chk("rst_mid_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid_err", 32'(err_cnt - e0), 32'd0);
    chk("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    send_ok("x55", 8'h55, 11'b1_1_01010101_0, 1'b0, 1'b0);

`ifdef PS2_TX_GLITCH_FILTER_EN
    send_ok("glitch", 8'hED, 11'b1_1_11101101_0, 1'b0, 1'b1);
`endif

    chk("done_err_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
